// File: rtl/axi_lite_master.sv
// AXI-Lite single-outstanding master: command in, AW/W or AR/R out, one response back per command.
// Latency: 3 cycles from command handshake to rsp_valid with slave ready high; every valid holds until its handshake.
// Optional read-data timeout under `AXI_MASTER_TIMEOUT_EN (off by default: RD_DATA waits forever, rsp_err tied 0).
module axi_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_addr_valid,
  input  logic              write_addr_ready,
  output logic [DATA_W-1:0] write_data,
  output logic              write_data_valid,
  input  logic              write_data_ready,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_addr_valid,
  input  logic              read_addr_ready,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              read_data_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi_lite_master: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] state;
  logic       aw_done;
  logic       w_done;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      write_addr       <= '0;
      write_addr_valid <= 1'b0;
      write_data       <= '0;
      write_data_valid <= 1'b0;
      read_addr        <= '0;
      read_addr_valid  <= 1'b0;
      read_data_ready  <= 1'b0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      rsp_err          <= 1'b0;
      tmo_cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_rdata <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            if (cmd_write) begin
              write_addr       <= cmd_addr;
              write_data       <= cmd_wdata;
              write_addr_valid <= 1'b1;
              write_data_valid <= 1'b1;
              aw_done          <= 1'b0;
              w_done           <= 1'b0;
              state            <= WRITE;
            end else begin
              read_addr       <= cmd_addr;
              read_addr_valid <= 1'b1;
              state           <= RD_ADDR;
            end
          end
        end

        // AW and W retire independently; completion is judged on the
        // registered done flags, which gives the fixed 3-cycle minimum.
        WRITE: begin
          if (write_addr_valid && write_addr_ready) begin
            write_addr_valid <= 1'b0;
            aw_done          <= 1'b1;
          end
          if (write_data_valid && write_data_ready) begin
            write_data_valid <= 1'b0;
            w_done           <= 1'b1;
          end
          if (aw_done && w_done) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RD_ADDR: begin
          if (read_addr_valid && read_addr_ready) begin
            read_addr_valid <= 1'b0;
            read_data_ready <= 1'b1;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            state           <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (read_data_valid && read_data_ready) begin
            rsp_rdata       <= read_data;
            read_data_ready <= 1'b0;
            rsp_valid       <= 1'b1;
            state           <= RESP;
          end
`ifdef AXI_MASTER_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata       <= '0;
            rsp_err         <= 1'b1;
            read_data_ready <= 1'b0;
            rsp_valid       <= 1'b1;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: linear steps, immediate assertions, hand-computed expectations.
module tb_axi_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] write_addr, read_addr;
  logic [DW-1:0] write_data, read_data;
  logic          write_addr_valid, write_addr_ready;
  logic          write_data_valid, write_data_ready;
  logic          read_addr_valid, read_addr_ready;
  logic          read_data_valid, read_data_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .write_addr(write_addr), .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
    .write_data(write_data), .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .read_addr(read_addr), .read_addr_valid(read_addr_valid), .read_addr_ready(read_addr_ready),
    .read_data(read_data), .read_data_valid(read_data_valid), .read_data_ready(read_data_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    write_addr_ready = 1'b1; write_data_ready = 1'b1; read_addr_ready = 1'b1;
    read_data = '0; read_data_valid = 1'b0;

    // Reset state
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_awvalid", 64'(write_addr_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk); rstn = 1'b1;
    tick();
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write addr=15 data=100, slave readies high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd15; cmd_wdata = 32'd100;
    tick();
    cmd_valid = 1'b0;
    check("wr_awvalid", 64'(write_addr_valid), 64'd1);
    check("wr_wvalid", 64'(write_data_valid), 64'd1);
    check("wr_addr", 64'(write_addr), 64'd15);
    check("wr_data", 64'(write_data), 64'd100);
    check("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    tick();
    check("wr_awvalid_drop", 64'(write_addr_valid), 64'd0);
    check("wr_wvalid_drop", 64'(write_data_valid), 64'd0);
    check("wr_rsp_not_yet", 64'(rsp_valid), 64'd0);
    tick();
    check("wr_rsp_lat3", 64'(rsp_valid), 64'd1);
    check("wr_rdata_zero", 64'(rsp_rdata), 64'd0);
    tick();
    check("wr_rsp_done", 64'(rsp_valid), 64'd0);
    check("wr_idle_ready", 64'(cmd_ready), 64'd1);

    // Stray read data while idle must be ignored
    read_data_valid = 1'b1; read_data = 32'hDEAD;
    tick();
    read_data_valid = 1'b0;
    tick();
    check("stray_r_ignored", 64'(rsp_valid), 64'd0);

    // Read addr=15, slave returns 100 two cycles after read_data_ready
    issue(1'b0, 32'd15, '0);
    check("rd_arvalid", 64'(read_addr_valid), 64'd1);
    check("rd_araddr", 64'(read_addr), 64'd15);
    tick();
    check("rd_rready", 64'(read_data_ready), 64'd1);
    check("rd_arvalid_drop", 64'(read_addr_valid), 64'd0);
    tick();
    check("rd_wait", 64'(rsp_valid), 64'd0);
    read_data_valid = 1'b1; read_data = 32'd100;
    tick();
    read_data_valid = 1'b0;
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rdata", 64'(rsp_rdata), 64'd100);
    check("rd_err", 64'(rsp_err), 64'd0);
    check("rd_rready_drop", 64'(read_data_ready), 64'd0);
    tick();
    check("rd_rsp_done", 64'(rsp_valid), 64'd0);

    // Write with AW accepted 4 cycles after W
    write_addr_ready = 1'b0;
    issue(1'b1, 32'h20, 32'h55);
    check("stag_both_valid", 64'({write_addr_valid, write_data_valid}), 64'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stag_w_dropped", 64'(write_data_valid), 64'd0);
      check("stag_aw_held", 64'(write_addr_valid), 64'd1);
      check("stag_aw_stable", 64'(write_addr), 64'h20);
      check("stag_no_rsp", 64'(rsp_valid), 64'd0);
    end
    write_addr_ready = 1'b1;
    tick();
    write_addr_ready = 1'b1;
    check("stag_aw_drop", 64'(write_addr_valid), 64'd0);
    check("stag_rsp_wait", 64'(rsp_valid), 64'd0);
    tick();
    check("stag_rsp", 64'(rsp_valid), 64'd1);
    tick();
    check("stag_single_rsp_a", 64'(rsp_valid), 64'd0);
    tick();
    check("stag_single_rsp_b", 64'(rsp_valid), 64'd0);

    // Response backpressure: rsp_ready low for 5 cycles
    rsp_ready = 1'b0;
    issue(1'b0, 32'h40, '0);
    read_data_valid = 1'b1; read_data = 32'hA5;
    wait_rsp("bp_rsp_arrive");
    read_data_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_held", 64'(rsp_valid), 64'd1);
      check("bp_rdata_held", 64'(rsp_rdata), 64'hA5);
      check("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_rsp_released", 64'(rsp_valid), 64'd0);
    check("bp_idle_ready", 64'(cmd_ready), 64'd1);

    // Reset while waiting in RD_DATA
    issue(1'b0, 32'h50, '0);
    tick();
    check("rstmid_in_rdata", 64'(read_data_ready), 64'd1);
    tick();
    rstn = 1'b0;
    #1;
    check("rstmid_rready", 64'(read_data_ready), 64'd0);
    check("rstmid_rdata", 64'(rsp_rdata), 64'd0);
    check("rstmid_araddr", 64'(read_addr), 64'd0);
    check("rstmid_waddr", 64'(write_addr), 64'd0);
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'd0);
    read_data_valid = 1'b1; read_data = 32'hBAD;
    tick();
    @(negedge clk); rstn = 1'b1;
    tick();
    read_data_valid = 1'b0;
    check("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
    check("rstmid_ready_again", 64'(cmd_ready), 64'd1);
    issue(1'b0, 32'h30, '0);
    read_data_valid = 1'b1; read_data = 32'h77;
    wait_rsp("rstmid_next_rsp");
    read_data_valid = 1'b0;
    check("rstmid_next_rdata", 64'(rsp_rdata), 64'h77);
    check("rstmid_next_err", 64'(rsp_err), 64'd0);
    tick();

`ifdef AXI_MASTER_TIMEOUT_EN
    // No read data: timeout after 16 cycles in RD_DATA
    begin
      int n_wait;
      int n_guard;
      n_wait = 0;
      n_guard = 0;
      issue(1'b0, 32'h60, '0);
      while (!rsp_valid && n_guard < 100) begin
        tick();
        n_guard++;
        if (!rsp_valid && read_data_ready) n_wait++;
      end
      check("tmo_rsp", 64'(rsp_valid), 64'd1);
      check("tmo_cycles", 64'(n_wait), 64'd16);
      check("tmo_err", 64'(rsp_err), 64'd1);
      check("tmo_rdata", 64'(rsp_rdata), 64'd0);
      check("tmo_rready", 64'(read_data_ready), 64'd0);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
